ltpi_link_aligned: RTL and testbench

//  Receive-side frame aligner for the LTPI (LVDS Tunneling Protocol Interface) link.

---
 rtl/ltpi_link_aligned_if.sv | 29 ++
 rtl/ltpi_link_aligned.sv | 168 ++++++++++++++++
 tb/tb_ltpi_link_aligned.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ltpi_link_aligned_if.sv
// Byte-stream bundle between the 8b10b decoder, the LTPI frame aligner and the frame parser.
// The master side drives decoded rx_* bytes; the slave side (aligner) returns frame-indexed bytes and status.
interface ltpi_link_aligned_if #(
  parameter int FRAME_LEN = 16
);
  localparam int IDX_W = $clog2(FRAME_LEN);

  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_k;
  logic             rx_err;
  logic             aligned;
  logic             align_lost;
  logic             frm_valid;
  logic             frm_start;
  logic [IDX_W-1:0] frm_idx;
  logic [7:0]       frm_data;
  logic [15:0]      bad_frm_cnt;

  modport master (
    output rx_valid, rx_data, rx_k, rx_err,
    input  aligned, align_lost, frm_valid, frm_start, frm_idx, frm_data, bad_frm_cnt
  );

  modport slave (
    input  rx_valid, rx_data, rx_k, rx_err,
    output aligned, align_lost, frm_valid, frm_start, frm_idx, frm_data, bad_frm_cnt
  );
endinterface

// File: rtl/ltpi_link_aligned.sv
// LTPI receive frame aligner: hunts for the K28.5 comma, locks after LOCK_FRAMES well-spaced
// frames, then emits frame-indexed bytes and drops lock after UNLOCK_ERRS consecutive bad frames.
module ltpi_link_aligned #(
  parameter int         FRAME_LEN   = 16,
  parameter int         LOCK_FRAMES = 7,
  parameter int         UNLOCK_ERRS = 3,
  parameter logic [7:0] COMMA       = 8'hBC
) (
  input  logic               clk,
  input  logic               reset,
  ltpi_link_aligned_if.slave link
);
  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int GOOD_W = $clog2(LOCK_FRAMES + 1);
  localparam int RUN_W  = $clog2(UNLOCK_ERRS + 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(FRAME_LEN - 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_FRAMES - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(UNLOCK_ERRS - 1);

  typedef enum logic [1:0] {HUNT, LOCKING, ALIGNED} state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [GOOD_W-1:0] good, good_nxt;
  logic [RUN_W-1:0]  bad_run, bad_run_nxt;
  logic              frame_bad, frame_bad_nxt;
  logic [15:0]       cnt, cnt_nxt;
  logic              lost_nxt;
  logic              emit;

  logic             aligned_p1;
  logic             lost_p1;
  logic             vld_p1;
  logic             start_p1;
  logic [IDX_W-1:0] idx_p1;
  logic [7:0]       data_p1;

  logic             is_comma;
  logic             at_zero;
  logic             byte_bad;
  logic [IDX_W-1:0] idx_inc;

  assign is_comma = link.rx_valid & link.rx_k & ~link.rx_err & (link.rx_data == COMMA);
  assign at_zero  = (idx == '0);
  assign idx_inc  = idx + IDX_W'(1);
  // A byte spoils its frame if the comma is missing/misplaced or the decoder flagged it.
  assign byte_bad = (at_zero ^ is_comma) | link.rx_err;

  always_comb begin
    state_nxt     = state;
    idx_nxt       = idx;
    good_nxt      = good;
    bad_run_nxt   = bad_run;
    frame_bad_nxt = frame_bad;
    cnt_nxt       = cnt;
    lost_nxt      = 1'b0;
    emit          = 1'b0;
    case (state)
      HUNT: begin
        if (is_comma) begin
          state_nxt = LOCKING;
          good_nxt  = GOOD_W'(1);
          idx_nxt   = IDX_W'(1);
        end
      end
      LOCKING: begin
        if (link.rx_valid) begin
          if (at_zero) begin
            if (is_comma) begin
              good_nxt = good + GOOD_W'(1);
              idx_nxt  = idx_inc;
              if (good == GOOD_LAST) begin
                state_nxt     = ALIGNED;
                emit          = 1'b1;
                bad_run_nxt   = '0;
                frame_bad_nxt = 1'b0;
              end
            end else begin
              state_nxt = HUNT;
            end
          end else if (is_comma) begin
            good_nxt = GOOD_W'(1);
            idx_nxt  = IDX_W'(1);
          end else if (link.rx_err) begin
            state_nxt = HUNT;
          end else begin
            idx_nxt = idx_inc;
          end
        end
      end
      ALIGNED: begin
        if (link.rx_valid) begin
          emit    = 1'b1;
          idx_nxt = idx_inc;
          if (idx == IDX_LAST) begin
            frame_bad_nxt = 1'b0;
            if (frame_bad | byte_bad) begin
              cnt_nxt = sat_inc16(cnt);
              if (bad_run == RUN_LAST) begin
                state_nxt   = HUNT;
                lost_nxt    = 1'b1;
                bad_run_nxt = '0;
              end else begin
                bad_run_nxt = bad_run + RUN_W'(1);
              end
            end else begin
              bad_run_nxt = '0;
            end
          end else begin
            frame_bad_nxt = frame_bad | byte_bad;
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= HUNT;
      idx       <= '0;
      good      <= '0;
      bad_run   <= '0;
      frame_bad <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      good      <= good_nxt;
      bad_run   <= bad_run_nxt;
      frame_bad <= frame_bad_nxt;
      cnt       <= cnt_nxt;
    end
  end

  // Output stage: accepted byte and status appear one cycle after input.
  always_ff @(posedge clk) begin
    if (reset) begin
      aligned_p1 <= 1'b0;
      lost_p1    <= 1'b0;
      vld_p1     <= 1'b0;
      start_p1   <= 1'b0;
      idx_p1     <= '0;
      data_p1    <= '0;
    end else begin
      aligned_p1 <= (state_nxt == ALIGNED);
      lost_p1    <= lost_nxt;
      vld_p1     <= emit;
      start_p1   <= emit & at_zero;
      if (emit) begin
        idx_p1  <= idx;
        data_p1 <= link.rx_data;
      end
    end
  end

  assign link.aligned     = aligned_p1;
  assign link.align_lost  = lost_p1;
  assign link.frm_valid   = vld_p1;
  assign link.frm_start   = start_p1;
  assign link.frm_idx     = idx_p1;
  assign link.frm_data    = data_p1;
  assign link.bad_frm_cnt = cnt;
endmodule

// File: tb/tb_ltpi_link_aligned.sv
// Bench for ltpi_link_aligned: directed lock/unlock scenarios plus randomized corrupted traffic,
// all checked every cycle against a byte-level reference model of the alignment rules.
module tb_ltpi_link_aligned;
  localparam int         FL    = 16;
  localparam int         LOCKN = 7;
  localparam int         UNLN  = 3;
  localparam logic [7:0] K285  = 8'hBC;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ltpi_link_aligned_if #(.FRAME_LEN(FL)) link();

  ltpi_link_aligned #(
    .FRAME_LEN(FL), .LOCK_FRAMES(LOCKN), .UNLOCK_ERRS(UNLN), .COMMA(K285)
  ) dut (
    .clk(clk),
    .reset(reset),
    .link(link)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_lost   = 0;
  bit chk_en   = 1'b0;

  // Reference model: mode 0 = hunting, 1 = counting commas, 2 = aligned.
  int m_mode = 0, m_pos = 0, m_commas = 0, m_run = 0, m_cnt = 0;
  bit m_flaw = 0;
  bit p_aligned = 0, p_lost = 0, p_valid = 0, p_start = 0;
  int p_idx = 0;
  logic [7:0] p_data = 8'h00;
  bit e_aligned = 0, e_lost = 0, e_valid = 0, e_start = 0;
  int e_idx = 0, e_cnt = 0;
  logic [7:0] e_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input logic [7:0] d, input bit k, input bit e);
    bit comma, bad;
    p_lost  = 0;
    p_valid = 0;
    if (r) begin
      m_mode = 0; m_pos = 0; m_commas = 0; m_run = 0; m_cnt = 0; m_flaw = 0;
      p_idx = 0; p_data = 8'h00;
    end else if (v) begin
      comma = k && !e && (d == K285);
      case (m_mode)
        0: if (comma) begin m_mode = 1; m_commas = 1; m_pos = 1; end
        1: begin
          if (m_pos == 0) begin
            if (comma) begin
              m_commas++;
              m_pos = 1;
              if (m_commas == LOCKN) begin
                m_mode = 2; m_run = 0; m_flaw = 0;
                p_valid = 1; p_idx = 0; p_data = d;
              end
            end else m_mode = 0;
          end else if (comma) begin
            m_commas = 1; m_pos = 1;
          end else if (e) m_mode = 0;
          else m_pos = (m_pos + 1) % FL;
        end
        default: begin
          bad = ((m_pos == 0) != comma) || e;
          p_valid = 1; p_idx = m_pos; p_data = d;
          if (m_pos == FL - 1) begin
            if (m_flaw || bad) begin
              if (m_cnt < 65535) m_cnt++;
              m_run++;
              if (m_run == UNLN) begin m_mode = 0; p_lost = 1; m_run = 0; end
            end else m_run = 0;
            m_flaw = 0;
          end else m_flaw = m_flaw || bad;
          m_pos = (m_pos + 1) % FL;
        end
      endcase
    end
    p_start   = p_valid && (p_idx == 0);
    p_aligned = (m_mode == 2);
  endtask

  task automatic tick(input bit r, input bit v, input logic [7:0] d, input bit k, input bit e);
    reset = r;
    link.rx_valid = v;
    link.rx_data  = d;
    link.rx_k     = k;
    link.rx_err   = e;
    model_step(r, v, d, k, e);
    @(posedge clk);
    #1;
    e_aligned = p_aligned; e_lost = p_lost; e_valid = p_valid; e_start = p_start;
    e_idx = p_idx; e_data = p_data; e_cnt = m_cnt;
    chk_en = 1'b1;
  endtask

  task automatic gaps(input int pct);
    while ($urandom_range(0, 99) < pct)
      tick(0, 0, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic head(input bit good, input int pct);
    gaps(pct);
    if (good) tick(0, 1, K285, 1, 0);
    else tick(0, 1, 8'h00, 0, 0);
  endtask

  task automatic body(input int n, input int pct);
    for (int i = 0; i < n; i++) begin
      gaps(pct);
      tick(0, 1, 8'($urandom_range(1, 255)), 0, 0);
    end
  endtask

  task automatic frame(input bit good, input int pct);
    head(good, pct);
    body(FL - 1, pct);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("aligned",     32'(link.aligned),     32'(e_aligned));
      check("align_lost",  32'(link.align_lost),  32'(e_lost));
      check("frm_valid",   32'(link.frm_valid),   32'(e_valid));
      check("frm_start",   32'(link.frm_start),   32'(e_start));
      check("frm_idx",     32'(link.frm_idx),     32'(e_idx));
      check("frm_data",    32'(link.frm_data),    32'(e_data));
      check("bad_frm_cnt", 32'(link.bad_frm_cnt), 32'(e_cnt));
      if (link.align_lost) n_lost++;
    end
  end

  initial begin
    link.rx_valid = 0; link.rx_data = 8'h00; link.rx_k = 0; link.rx_err = 0;
    tick(1, 0, 8'h00, 0, 0);
    tick(1, 1, K285, 1, 0);
    check("rst_aligned",   32'(link.aligned),     32'd0);
    check("rst_frm_valid", 32'(link.frm_valid),   32'd0);
    check("rst_cnt",       32'(link.bad_frm_cnt), 32'd0);

    // Clean lock: 7th comma appears aligned with frm_start.
    repeat (6) frame(1, 0);
    check("s1_pre_lock", 32'(link.aligned), 32'd0);
    head(1, 0);
    check("s1_lock_aligned", 32'(link.aligned),   32'd1);
    check("s1_lock_start",   32'(link.frm_start), 32'd1);
    check("s1_lock_valid",   32'(link.frm_valid), 32'd1);
    body(FL - 1, 0);
    check("s1_idx15", 32'(link.frm_idx), 32'd15);
    head(1, 0);
    check("s1_wrap_start", 32'(link.frm_start), 32'd1);
    check("s1_wrap_idx",   32'(link.frm_idx),   32'd0);
    body(FL - 1, 0);

    // Missing comma during locking returns to hunt.
    tick(1, 0, 8'h00, 0, 0);
    repeat (6) frame(1, 0);
    head(0, 0);
    check("s2_no_lock", 32'(link.aligned), 32'd0);
    body(FL - 1, 0);
    repeat (6) frame(1, 0);
    check("s2_pre_lock", 32'(link.aligned), 32'd0);
    head(1, 0);
    check("s2_lock", 32'(link.aligned), 32'd1);
    body(FL - 1, 0);

    // Misplaced comma at idx 5 restarts the count from itself.
    tick(1, 0, 8'h00, 0, 0);
    repeat (3) frame(1, 0);
    head(1, 0);
    body(4, 0);
    head(1, 0);
    body(FL - 1, 0);
    repeat (5) frame(1, 0);
    check("s3_pre_lock", 32'(link.aligned), 32'd0);
    head(1, 0);
    check("s3_lock", 32'(link.aligned), 32'd1);
    body(FL - 1, 0);

    // Two bad, one good, three bad frames: one unlock, five bad frames counted.
    n_lost = 0;
    repeat (2) frame(0, 0);
    check("s4_still_aligned", 32'(link.aligned), 32'd1);
    frame(1, 0);
    repeat (3) frame(0, 0);
    check("s4_unlocked", 32'(link.aligned),     32'd0);
    check("s4_cnt",      32'(link.bad_frm_cnt), 32'd5);
    tick(0, 0, 8'h00, 0, 0);
    check("s4_lost_pulses", 32'(n_lost), 32'd1);

    // Reset mid-frame while aligned clears everything; relock takes 7 fresh frames.
    repeat (LOCKN) frame(1, 0);
    body(8, 0);
    tick(1, 1, 8'h5A, 0, 0);
    check("s6_rst_aligned", 32'(link.aligned),     32'd0);
    check("s6_rst_valid",   32'(link.frm_valid),   32'd0);
    check("s6_rst_idx",     32'(link.frm_idx),     32'd0);
    check("s6_rst_data",    32'(link.frm_data),    32'd0);
    check("s6_rst_cnt",     32'(link.bad_frm_cnt), 32'd0);
    repeat (6) frame(1, 0);
    check("s6_pre_relock", 32'(link.aligned), 32'd0);
    head(1, 0);
    check("s6_relock", 32'(link.aligned), 32'd1);
    body(FL - 1, 0);

    // Reset coinciding with the unlocking byte suppresses align_lost.
    n_lost = 0;
    repeat (2) frame(0, 0);
    head(0, 0);
    body(FL - 2, 0);
    tick(1, 1, 8'h11, 0, 0);
    check("s7_lost", 32'(link.align_lost), 32'd0);
    check("s7_aligned", 32'(link.aligned), 32'd0);
    tick(0, 0, 8'h00, 0, 0);
    check("s7_lost_pulses", 32'(n_lost), 32'd0);

    // Clean frames with ~50% valid gaps lock at the same comma.
    repeat (6) frame(1, 50);
    check("s5_pre_lock", 32'(link.aligned), 32'd0);
    head(1, 50);
    check("s5_lock", 32'(link.aligned), 32'd1);
    body(FL - 1, 50);

    // Randomized traffic alternating quiet and noisy epochs.
    for (int f = 0; f < 160; f++) begin
      int rate, kind, where, ewhere;
      bit bad;
      rate   = ((f / 20) % 2 == 0) ? 5 : 60;
      bad    = ($urandom_range(0, 99) < rate);
      kind   = $urandom_range(0, 2);
      where  = $urandom_range(1, FL - 1);
      ewhere = $urandom_range(0, FL - 1);
      for (int i = 0; i < FL; i++) begin
        logic [7:0] d;
        bit k, e;
        gaps(30);
        if ($urandom_range(0, 999) < 2) begin
          tick(1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
          continue;
        end
        d = (i == 0) ? K285 : 8'($urandom);
        k = (i == 0);
        if (bad && kind == 0 && i == 0) begin d = 8'($urandom); k = 0; end
        if (bad && kind == 2 && i == where) begin d = K285; k = 1; end
        e = bad && kind == 1 && i == ewhere;
        tick(0, 1, d, k, e);
      end
    end
    tick(0, 0, 8'h00, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
